// File: rtl/cdb_arbiter.sv
// Round-robin owner of the common data bus: picks one ready functional unit
// per cycle and drives the registered CDB broadcast plus statistics.
module cdb_arbiter #(
    parameter int N      = 3,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [N-1:0]        rts,
    input  logic [N*TAG_W-1:0]  src_tags,
    input  logic [N*DATA_W-1:0] src_data,
    input  logic                stall,
    output logic [N-1:0]        xmit,
    output logic                CDB_write,
    output logic [TAG_W-1:0]    CDB_source,
    output logic [DATA_W-1:0]   CDB_data,
    output logic                tag_error,
    output logic [CNT_W-1:0]    broadcast_count
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]     ptr;
    logic [PW-1:0]     win;
    logic [PW-1:0]     win_next;
    logic [PW-1:0]     idx;
    logic              found;
    logic              grant;
    logic [N-1:0]      eligible;
    logic [TAG_W-1:0]  tag_arr  [N];
    logic [DATA_W-1:0] data_arr [N];

    // A unit on the bus this cycle sits out the edge that ends it.
    assign eligible = rts & ~xmit;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            tag_arr[i]  = src_tags[i*TAG_W +: TAG_W];
            data_arr[i] = src_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign grant    = found && !stall;
    assign win_next = (win == PW'(N - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            xmit            <= '0;
            CDB_write       <= 1'b0;
            CDB_source      <= '0;
            CDB_data        <= '0;
            tag_error       <= 1'b0;
            broadcast_count <= '0;
            ptr             <= '0;
        end else if (grant) begin
            xmit       <= N'(1) << win;
            CDB_write  <= 1'b1;
            CDB_source <= tag_arr[win];
            CDB_data   <= data_arr[win];
            tag_error  <= (tag_arr[win] == '0);
            ptr        <= win_next;
            if (broadcast_count != '1)
                broadcast_count <= broadcast_count + 1'b1;
        end else begin
            // Source and data hold; consumers qualify them with CDB_write.
            xmit      <= '0;
            CDB_write <= 1'b0;
            tag_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic, all checked
// against a cycle-level reference model of the bus-ownership rules.
module tb_cdb_arbiter;

    localparam int N      = 3;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic [N-1:0]        rts = '0;
    logic [N*TAG_W-1:0]  src_tags = '0;
    logic [N*DATA_W-1:0] src_data = '0;
    logic                stall = 1'b0;
    logic [N-1:0]        xmit;
    logic                CDB_write;
    logic [TAG_W-1:0]    CDB_source;
    logic [DATA_W-1:0]   CDB_data;
    logic                tag_error;
    logic [CNT_W-1:0]    broadcast_count;

    int n_cmp = 0;
    int n_bad = 0;

    int          m_ptr;
    int          m_last;
    bit          m_write;
    logic [63:0] m_src;
    logic [63:0] m_data;
    bit          m_terr;
    int          m_cnt;

    cdb_arbiter #(.N(N), .TAG_W(TAG_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .rts(rts),
        .src_tags(src_tags),
        .src_data(src_data),
        .stall(stall),
        .xmit(xmit),
        .CDB_write(CDB_write),
        .CDB_source(CDB_source),
        .CDB_data(CDB_data),
        .tag_error(tag_error),
        .broadcast_count(broadcast_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_unit(input int i, input int tag, input logic [31:0] d);
        src_tags[i*TAG_W +: TAG_W]   = TAG_W'(tag);
        src_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_last = -1; m_write = 0;
        m_src = 0; m_data = 0; m_terr = 0; m_cnt = 0;
    endtask

    // Bus ownership rules: first requester at or after the pointer, never the
    // unit currently on the bus, nothing while stalled.
    task automatic model_edge();
        int w;
        w = -1;
        if (!stall) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (w < 0 && rts[i] && i != m_last) w = i;
            end
        end
        if (w >= 0) begin
            m_last  = w;
            m_write = 1;
            m_src   = 64'(src_tags[w*TAG_W +: TAG_W]);
            m_data  = 64'(src_data[w*DATA_W +: DATA_W]);
            m_terr  = (m_src == 0);
            m_cnt   = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            m_ptr   = (w + 1) % N;
        end else begin
            m_last  = -1;
            m_write = 0;
            m_terr  = 0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [63:0] ex;
        ex = (m_last >= 0) ? (64'd1 << m_last) : 64'd0;
        check({tag, ".xmit"}, 64'(xmit), ex);
        check({tag, ".write"}, 64'(CDB_write), 64'(m_write));
        check({tag, ".src"}, 64'(CDB_source), m_src);
        check({tag, ".data"}, 64'(CDB_data), m_data);
        check({tag, ".terr"}, 64'(tag_error), 64'(m_terr));
        check({tag, ".cnt"}, 64'(broadcast_count), 64'(m_cnt));
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("rst");
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        check_all("por");
        @(negedge clock);
        reset_n = 1'b1;

        // Single requester holding rts: grant every other edge.
        set_unit(0, 5, 32'h1234);
        rts = 3'b001;
        step("single1");
        check("single.xmit", 64'(xmit), 64'h1);
        check("single.src", 64'(CDB_source), 64'd5);
        check("single.data", 64'(CDB_data), 64'h1234);
        step("single2");
        check("single.gap", 64'(CDB_write), 64'd0);
        step("single3");
        step("single4");
        check("single.cnt", 64'(broadcast_count), 64'd2);

        // All three from reset, each drops rts during its own xmit cycle.
        rts = '0;
        do_reset();
        set_unit(0, 10, 32'hA0);
        set_unit(1, 11, 32'hA1);
        set_unit(2, 12, 32'hA2);
        rts = 3'b111;
        for (int k = 0; k < 3; k++) begin
            step("all3");
            check("all3.src", 64'(CDB_source), 64'(10 + k));
            rts = rts & ~xmit;
        end
        check("all3.ptr", 64'(dut.ptr), 64'd0);

        // Fairness between two permanent requesters.
        do_reset();
        rts = 3'b101;
        for (int k = 0; k < 6; k++) begin
            step("fair");
            check("fair.write", 64'(CDB_write), 64'd1);
            check("fair.xmit", 64'(xmit), (k % 2 == 0) ? 64'h1 : 64'h4);
        end

        // Stall holds off a pending request.
        rts = '0;
        do_reset();
        rts = 3'b010;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step("stall");
            check("stall.write", 64'(CDB_write), 64'd0);
        end
        stall = 1'b0;
        step("unstall");
        check("unstall.xmit", 64'(xmit), 64'h2);

        // Zero tag: broadcast still happens, error pulses once.
        rts = '0;
        step("idle");
        set_unit(1, 0, 32'hFFFF);
        rts = 3'b010;
        step("ztag");
        check("ztag.terr", 64'(tag_error), 64'd1);
        check("ztag.data", 64'(CDB_data), 64'hFFFF);
        rts = '0;
        step("ztag2");
        check("ztag2.terr", 64'(tag_error), 64'd0);

        // Async reset in the middle of a broadcast cycle.
        set_unit(0, 7, 32'h77);
        set_unit(1, 8, 32'h88);
        rts = 3'b011;
        step("pre_rst");
        check("pre_rst.write", 64'(CDB_write), 64'd1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clock);
        reset_n = 1'b1;
        set_unit(2, 9, 32'h99);
        rts = 3'b100;
        step("post_rst");
        check("post_rst.xmit", 64'(xmit), 64'h4);
        check("post_rst.cnt", 64'(broadcast_count), 64'd1);
        rts = '0;
        step("post_idle");

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            rts   = N'($urandom);
            stall = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < N; i++)
                set_unit(i, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom),
                         $urandom);
            step("rand");
        end

        // Counter saturation with back-to-back broadcasts.
        stall = 1'b0;
        rts   = '0;
        do_reset();
        rts = 3'b101;
        for (int k = 0; k < CMAX + 3; k++) begin
            @(posedge clock);
            model_edge();
        end
        #1;
        check_all("sat");
        check("sat.cnt", 64'(broadcast_count), 64'(CMAX));
        step("sat2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
